// File: rtl/shreg_sequencer.sv
// Command sequencer for a circular shift register: CLEAR / LOAD / ROTATE over valid/ready, with a shadow mirror.
// Optional: define SHREG_SEQ_CHECK_EN to compare live sr_q against the mirror while idle (sticky mismatch).
module shreg_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             sr_clear,
  output logic             sr_shift_en,
  output logic             sr_din,
  input  logic [WIDTH-1:0] sr_q,
  output logic [WIDTH-1:0] mirror_q,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_ROT   = 2'b11;
  // Counter must hold both a full ROTATE count and WIDTH for LOAD.
  localparam int LW = $clog2(WIDTH + 1);
  localparam int CW = (CNT_W > LW) ? CNT_W : LW;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_ROT, S_DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] data_r, data_n, mirror_n;
  logic             load_r, load_n;
  logic             accept;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid & cmd_ready & ena;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      data_r   <= '0;
      load_r   <= 1'b0;
      mirror_q <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      data_r   <= data_n;
      load_r   <= load_n;
      mirror_q <= mirror_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    data_n      = data_r;
    load_n      = load_r;
    mirror_n    = mirror_q;
    sr_clear    = 1'b0;
    sr_shift_en = 1'b0;
    sr_din      = 1'b0;
    done        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          load_n = (cmd_op == OP_LOAD);
          data_n = cmd_data;
          cnt_n  = CW'(cmd_count);
          case (cmd_op)
            OP_CLEAR, OP_LOAD: state_n = S_CLR;
            OP_ROT:            state_n = (cmd_count == '0) ? S_DONE : S_ROT;
            default:           state_n = S_IDLE;
          endcase
        end
      end
      S_CLR: begin
        sr_clear = ena;
        if (ena) begin
          mirror_n = '0;
          if (load_r) begin
            state_n = S_LOAD;
            cnt_n   = CW'(WIDTH);
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_LOAD, S_ROT: begin
        sr_shift_en = ena;
        // LOAD feeds the pattern MSB first; ROTATE just recirculates.
        sr_din      = (state == S_LOAD) && data_r[WIDTH-1];
        if (ena) begin
          mirror_n = {mirror_q[WIDTH-2:0], mirror_q[WIDTH-1] ^ sr_din};
          data_n   = {data_r[WIDTH-2:0], 1'b0};
          cnt_n    = cnt - CW'(1);
          if (cnt == CW'(1)) state_n = S_DONE;
        end
      end
      S_DONE: begin
        done = ena;
        if (ena) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef SHREG_SEQ_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mismatch <= 1'b0;
    else if (accept && (cmd_op == OP_CLEAR || cmd_op == OP_LOAD))
      mismatch <= 1'b0;
    else if (state == S_IDLE && ena && sr_q != mirror_q)
      mismatch <= 1'b1;
  end
`else
  logic unused_sr_q;
  assign unused_sr_q = ^sr_q;
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_shreg_sequencer.sv
// Bench for shreg_sequencer: directed and random commands against a reference model plus a behavioural shift register.
module tb_shreg_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, ena, cmd_valid, cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [7:0]   cmd_count;
  logic         sr_clear, sr_shift_en, sr_din;
  logic [W-1:0] sr_q, mirror_q, q_model, force_val;
  logic         force_en;
  logic         busy, done, mismatch;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_mirror;

  shreg_sequencer #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .sr_clear(sr_clear), .sr_shift_en(sr_shift_en), .sr_din(sr_din), .sr_q(sr_q),
    .mirror_q(mirror_q), .busy(busy), .done(done), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural shift register driven by the controller's strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              q_model <= '0;
    else if (sr_clear)    q_model <= '0;
    else if (sr_shift_en) q_model <= {q_model[W-2:0], q_model[W-1] ^ sr_din};
  end
  assign sr_q = force_en ? force_val : q_model;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
    int s;
    s = n % W;
    return (s == 0) ? v : ((v << s) | (v >> (W - s)));
  endfunction

  function automatic int base_latency(input logic [1:0] op, input int cnt);
    case (op)
      2'b01:   return 2;
      2'b10:   return W + 2;
      default: return (cnt == 0) ? 1 : cnt + 1;
    endcase
  endfunction

  // Issue one command, watch every cycle until done, compare against the model.
  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] data, input int cnt, input int gap_at);
    int lat, nclr, nsh, n_off, n_notbusy, exp_lat, exp_sh, exp_clr;
    logic [W-1:0] dins, exp_m;
    lat = 0; nclr = 0; nsh = 0; n_off = 0; n_notbusy = 0; dins = '0;
    exp_lat = base_latency(op, cnt) + ((gap_at >= 1 && gap_at <= base_latency(op, cnt)) ? 3 : 0);
    exp_sh  = (op == 2'b10) ? W : (op == 2'b11) ? cnt : 0;
    exp_clr = (op == 2'b01 || op == 2'b10) ? 1 : 0;
    exp_m   = (op == 2'b01) ? '0 : (op == 2'b10) ? data : rotl(exp_mirror, cnt);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = 8'(cnt);
    #1 chk("ready_before_accept", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_op = 2'b00;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      ena = !(gap_at >= 1 && i >= gap_at && i < gap_at + 3);
      #1;
      if (sr_clear) nclr++;
      if (sr_shift_en) begin
        nsh++;
        dins = {dins[W-2:0], sr_din};
      end
      if (!ena && (sr_clear || sr_shift_en)) n_off++;
      if (!busy) n_notbusy++;
      if (done) begin
        lat = i;
        break;
      end
    end
    ena = 1'b1;
    chk("latency", lat, exp_lat);
    chk("clear_strobes", nclr, exp_clr);
    chk("shift_strobes", nsh, exp_sh);
    chk("strobes_while_ena_low", n_off, 0);
    chk("busy_during_cmd", n_notbusy, 0);
    if (op == 2'b10) chk("load_din_sequence", dins, data);
    @(negedge clk);
    #1;
    exp_mirror = exp_m;
    chk("mirror_after_cmd", mirror_q, exp_mirror);
    chk("shreg_after_cmd", q_model, exp_mirror);
    chk("done_is_pulse", done, 0);
    chk("ready_after_cmd", cmd_ready, 1);
    chk("mismatch_clean", mismatch, 0);
  endtask

  initial begin
    int done_seen;
    logic [1:0] rop;
    logic [W-1:0] rdata;
    int rcnt, rgap;

    rst = 1'b1; ena = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; cmd_count = '0;
    force_en = 1'b0; force_val = '0; exp_mirror = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_sr_clear", sr_clear, 0);
    chk("rst_sr_shift_en", sr_shift_en, 0);
    chk("rst_sr_din", sr_din, 0);
    chk("rst_mirror", mirror_q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mismatch", mismatch, 0);
    rst = 1'b0;

    // Directed cases
    do_cmd(2'b10, 8'b10110110, 0, 0);
    do_cmd(2'b10, 8'h01, 0, 0);
    do_cmd(2'b11, '0, 8, 0);
    do_cmd(2'b10, 8'h80, 0, 0);
    do_cmd(2'b11, '0, 1, 0);
    do_cmd(2'b11, '0, 0, 0);
    do_cmd(2'b10, 8'hA5, 0, 4);
    do_cmd(2'b11, '0, 5, 3);
    do_cmd(2'b01, '0, 0, 0);

    // NOP: accepted, no done, nothing changes
    do_cmd(2'b10, 8'h3C, 0, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy || sr_shift_en || sr_clear) done_seen++;
    end
    chk("nop_no_activity", done_seen, 0);
    chk("nop_mirror", mirror_q, exp_mirror);

    // Reset mid-ROTATE
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_count = 8'd50;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_op = 2'b00;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_shift_en", sr_shift_en, 0);
    chk("midrst_mirror", mirror_q, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_mirror = '0;
    done_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("midrst_no_done", done_seen, 0);

    // Random command mix
    for (int k = 0; k < 20; k++) begin
      rop   = 2'($urandom_range(1, 3));
      rdata = 8'($urandom);
      rcnt  = $urandom_range(0, 20);
      rgap  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, base_latency(rop, rcnt)) : 0;
      do_cmd(rop, rdata, rcnt, rgap);
    end
    do_cmd(2'b11, '0, 255, 0);

`ifdef SHREG_SEQ_CHECK_EN
    do_cmd(2'b10, 8'h01, 0, 0);
    @(negedge clk);
    force_en = 1'b1; force_val = 8'h00;
    repeat (2) @(negedge clk);
    #1 chk("mismatch_set", mismatch, 1);
    force_en = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("mismatch_sticky", mismatch, 1);
    do_cmd(2'b01, '0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
